// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial pattern detector (Mealy). Each accepted bit is shifted
// into a history register. The match output y is formed combinationally from
// that history plus the current bit.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  reset/default pattern; bit PAT_W-1 is the first-received bit
//   OVERLAP  1: matches may share bits, 0: history restarts after a match
//   CNT_W    width of the saturating match counter (1..32)
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   en         sample qualifier; x is consumed only when en=1
//   x          serial data bit
//   pat_load   load pat_in as the active pattern and clear history
//   pat_in     new pattern value (same bit order as PATTERN)
//   cnt_clr    clear match counter and saturation flag
//   y          combinational match pulse
//   y_q        y delayed by one clock
//   match_cnt  saturating number of matches
//   cnt_sat    sticky flag, set once match_cnt reaches all-ones
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // fill only needs to reach PAT_W-1, so clog2(PAT_W) bits are enough.
    localparam int                FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;
    logic              accept;
    logic              full;
    logic [CNT_W-1:0]  cnt_inc;

    // The candidate window is the history plus the bit on the wire right now.
    // That gives zero-latency detection on the final pattern bit.
    assign window = {hist, x};
    assign accept = en & ~pat_load;
    assign full   = (fill == FILL_FULL);
    assign y      = accept & full & (window == pat_r);

    // -----------------------------------------------------------------------
    // Pattern / history / fill
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pat_r <= PATTERN;
            hist  <= '0;
            fill  <= '0;
        end else if (pat_load) begin
            // The bit on x in this cycle is discarded along with the history.
            pat_r <= pat_in;
            fill  <= '0;
        end else if (accept) begin
            // The low PAT_W-1 bits of the window are the shifted history.
            // This form also works for PAT_W=2, where hist is a single bit.
            hist <= window[PAT_W-2:0];
            if (y && !OVERLAP) begin
                // Non-overlapping: the bits of this match cannot be reused.
                // Restarting fill is enough, because stale hist bits are
                // ignored until fill is full again.
                fill <= '0;
            end else if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered match pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating match counter
    // -----------------------------------------------------------------------
    assign cnt_inc = match_cnt + 1'b1;

    // cnt_sat is high exactly when match_cnt is all-ones, because only
    // cnt_clr can lower either of them. It therefore doubles as the hold
    // condition.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (cnt_clr) begin
            // The clear has priority over a match in the same cycle.
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (y && !cnt_sat) begin
            match_cnt <= cnt_inc;
            if (cnt_inc == {CNT_W{1'b1}}) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       nrst, en, x, pat_load, cnt_clr;
    logic [3:0] pin;
    logic [1:0] pin2;

    always #5 clk = ~clk;
    assign pin2 = pin[1:0];

    // dut0: defaults, dut1: non-overlapping, dut2: 2-bit pattern with 2-bit counter
    logic       y0, y1, y2, yq0, yq1, yq2, s0, s1, s2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    seq_detector_param dut0 (
        .clk(clk), .nrst(nrst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin),
        .cnt_clr(cnt_clr), .y(y0), .y_q(yq0), .match_cnt(c0), .cnt_sat(s0));

    seq_detector_param #(.OVERLAP(1'b0)) dut1 (
        .clk(clk), .nrst(nrst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin),
        .cnt_clr(cnt_clr), .y(y1), .y_q(yq1), .match_cnt(c1), .cnt_sat(s1));

    seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .nrst(nrst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pin2),
        .cnt_clr(cnt_clr), .y(y2), .y_q(yq2), .match_cnt(c2), .cnt_sat(s2));

    int dy[3], dyq[3], dcnt[3], dsat[3];
    always_comb begin
        dy[0] = int'(y0);   dy[1] = int'(y1);   dy[2] = int'(y2);
        dyq[0] = int'(yq0); dyq[1] = int'(yq1); dyq[2] = int'(yq2);
        dcnt[0] = int'(c0); dcnt[1] = int'(c1); dcnt[2] = int'(c2);
        dsat[0] = int'(s0); dsat[1] = int'(s1); dsat[2] = int'(s2);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History is a queue of accepted bits since the last restart. A match is
    // the integer value of the last PAT_W bits, compared against the pattern.
    int mW[3]   = '{4, 4, 2};
    int mOV[3]  = '{1, 0, 1};
    int mMAX[3] = '{255, 255, 3};
    int mpat[3];
    int mcnt[3];
    int msat[3];
    int myq[3];
    bit mq[3][$];

    task automatic model_reset();
        mpat = '{13, 13, 3};
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            mcnt[d] = 0; msat[d] = 0; myq[d] = 0;
        end
    endtask

    function automatic int model_y(int d, bit e, bit ld, bit xv);
        int v;
        int n;
        if (!e || ld) return 0;
        n = mq[d].size();
        if (n < mW[d] - 1) return 0;
        v = 0;
        for (int i = n - (mW[d] - 1); i < n; i++) v = v * 2 + int'(mq[d][i]);
        v = v * 2 + int'(xv);
        return (v == mpat[d]) ? 1 : 0;
    endfunction

    task automatic model_step(int d, bit e, bit ld, bit xv, bit clr, int pv, int yv);
        if (ld) begin
            mpat[d] = pv;
            mq[d].delete();
        end else if (e) begin
            if (yv != 0 && mOV[d] == 0) mq[d].delete();
            else begin
                mq[d].push_back(xv);
                if (mq[d].size() > mW[d] - 1) void'(mq[d].pop_front());
            end
        end
        if (clr) begin
            mcnt[d] = 0; msat[d] = 0;
        end else if (yv != 0 && mcnt[d] != mMAX[d]) begin
            mcnt[d]++;
            if (mcnt[d] == mMAX[d]) msat[d] = 1;
        end
        myq[d] = yv;
    endtask

    // One clock cycle, entered and left at a falling edge: drive inputs,
    // check y mid-cycle, then check registered outputs just after the edge.
    task automatic cyc(bit e, bit xv, bit ld, bit clr, logic [3:0] p, output int yo[3]);
        int ey[3];
        en = e; x = xv; pat_load = ld; cnt_clr = clr; pin = p;
        #1;
        for (int d = 0; d < 3; d++) begin
            ey[d] = model_y(d, e, ld, xv);
            chk($sformatf("y%0d", d), dy[d], ey[d]);
            yo[d] = dy[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            model_step(d, e, ld, xv, clr, (d == 2) ? int'(p[1:0]) : int'(p), ey[d]);
            chk($sformatf("y_q%0d", d), dyq[d], myq[d]);
            chk($sformatf("cnt%0d", d), dcnt[d], mcnt[d]);
            chk($sformatf("sat%0d", d), dsat[d], msat[d]);
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit         e, xv, ld, clr;
        logic [3:0] p;
        bit         ey0, ey1;
    } vec_t;

    function automatic vec_t mk(bit e, bit xv, bit ld, logic [3:0] p, bit ey0, bit ey1);
        vec_t v;
        v.e = e; v.xv = xv; v.ld = ld; v.clr = 1'b0; v.p = p; v.ey0 = ey0; v.ey1 = ey1;
        return v;
    endfunction

    initial begin
        vec_t tbl[15];
        int   yo[3];
        int   pulses;
        bit   bits[4];

        // 1,1,0,1,1,0,1: overlapping matches on 4 and 7, non-overlapping on 4 only.
        tbl[0]  = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 4'h0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 4'h0, 1, 1);
        tbl[4]  = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 4'h0, 0, 0);
        tbl[6]  = mk(1, 1, 0, 4'h0, 1, 0);
        // 1,1,0, then a load of 0110 with en=1/x=1, then 0,1,1,0.
        tbl[7]  = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[8]  = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 4'h0, 0, 0);
        tbl[10] = mk(1, 1, 1, 4'b0110, 0, 0);
        tbl[11] = mk(1, 0, 0, 4'h0, 0, 0);
        tbl[12] = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[13] = mk(1, 1, 0, 4'h0, 0, 0);
        tbl[14] = mk(1, 0, 0, 4'h0, 1, 1);

        // ---- reset ----
        nrst = 1'b0; en = 1'b1; x = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0; pin = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_y%0d", d), dy[d], 0);
            chk($sformatf("rst_yq%0d", d), dyq[d], 0);
            chk($sformatf("rst_cnt%0d", d), dcnt[d], 0);
            chk($sformatf("rst_sat%0d", d), dsat[d], 0);
        end
        nrst = 1'b1;

        // ---- table vectors ----
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].e, tbl[i].xv, tbl[i].ld, tbl[i].clr, tbl[i].p, yo);
            chk($sformatf("tbl%0d_y0", i), yo[0], int'(tbl[i].ey0));
            chk($sformatf("tbl%0d_y1", i), yo[1], int'(tbl[i].ey1));
        end
        chk("tbl_cnt0", dcnt[0], 3);
        chk("tbl_cnt1", dcnt[1], 2);

        // ---- en gaps: 1,1,0,1 with two idle cycles between bits ----
        cyc(0, 0, 1, 1, 4'b1101, yo);
        bits = '{1, 1, 0, 1};
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, bits[i], 0, 0, 4'h0, yo);
            pulses += yo[0];
            if (i == 3) chk("gap_last_y0", yo[0], 1);
            if (i < 3) repeat (2) cyc(0, 1'($urandom_range(0, 1)), 0, 0, 4'h0, yo);
        end
        chk("gap_pulses0", pulses, 1);
        chk("gap_cnt0", dcnt[0], 1);

        // ---- saturation on the 2-bit counter ----
        cyc(0, 0, 1, 1, 4'hF, yo);
        for (int k = 1; k <= 6; k++) begin
            cyc(1, 1, 0, 0, 4'h0, yo);
            chk($sformatf("sat_y2_s%0d", k), yo[2], (k >= 2) ? 1 : 0);
            chk($sformatf("sat_cnt2_s%0d", k), dcnt[2], (k - 1 > 3) ? 3 : k - 1);
            chk($sformatf("sat_flag2_s%0d", k), dsat[2], (k >= 4) ? 1 : 0);
        end
        cyc(1, 1, 0, 1, 4'h0, yo);
        chk("clr_match_y2", yo[2], 1);
        chk("clr_match_cnt2", dcnt[2], 0);
        chk("clr_match_sat2", dsat[2], 0);

        // ---- asynchronous reset mid-pattern ----
        cyc(0, 0, 1, 0, 4'b1101, yo);
        cyc(1, 1, 0, 0, 4'h0, yo);
        cyc(1, 1, 0, 0, 4'h0, yo);
        cyc(1, 0, 0, 0, 4'h0, yo);
        en = 1'b1; x = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("arst_y%0d", d), dy[d], 0);
            chk($sformatf("arst_yq%0d", d), dyq[d], 0);
            chk($sformatf("arst_cnt%0d", d), dcnt[d], 0);
            chk($sformatf("arst_sat%0d", d), dsat[d], 0);
        end
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1, bits[i], 0, 0, 4'h0, yo);
            chk($sformatf("post_rst_y0_s%0d", i + 1), yo[0], (i == 3) ? 1 : 0);
        end

        // ---- randomized against the model ----
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
                4'($urandom_range(0, 15)), yo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector that generalises the fixed 4-state Mealy detector. Pattern width and pattern value are parameters, and the pattern can be reloaded at run time. The block supports overlapping and non-overlapping match modes, a sample-enable qualifier, a registered copy of the match pulse, and a saturating match counter. It sits on a serial bit stream between the bit source and the control logic that consumes match events.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, reset/default pattern; bit PAT_W-1 is the oldest (first-received) bit.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, match counter width; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  sample qualifier; x is consumed only when en=1.
- x  in  1  serial data bit.
- pat_load  in  1  synchronous load of pat_in; clears history.
- pat_in  in  PAT_W  new pattern value, same bit ordering as PATTERN.
- cnt_clr  in  1  synchronous clear of the match counter and saturation flag.
- y  out  1  Mealy match output, combinational from x, en, pat_load and state.
- y_q  out  1  y registered; high one cycle after y.
- match_cnt  out  CNT_W  number of matches; saturating.
- cnt_sat  out  1  sticky flag, set when match_cnt reaches all-ones.

## Operation
- State:
  - pat_r[PAT_W-1:0] holds the active pattern.
  - hist[PAT_W-2:0] holds the last PAT_W-1 accepted bits; hist[0] is the newest.
  - fill counts valid history bits, 0..PAT_W-1, saturating at PAT_W-1.
- Candidate window = {hist[PAT_W-2:0], x}.
- y = en & ~pat_load & (fill == PAT_W-1) & (window == pat_r).
- Accepted sample (en=1, pat_load=0):
  - hist shifts left and x enters hist[0].
  - fill increments, saturating at PAT_W-1.
- When y=1 and OVERLAP=0: fill is cleared to 0 instead of incremented. hist contents are don't-care.
- When y=1 and OVERLAP=1: normal shift; a later match may reuse bits from this one.
- en=0: hist, fill and counter are held; y=0.
- pat_load=1: pat_r ← pat_in and fill ← 0. Any x in that cycle is discarded and y=0. pat_load wins over en.
- Counter:
  - On y=1, match_cnt increments.
  - When match_cnt reaches 2^CNT_W-1, cnt_sat is set and match_cnt holds at that value.
  - cnt_clr=1 clears match_cnt and cnt_sat. cnt_clr wins over a same-cycle match, so the result is 0 and y itself still pulses.
- pat_load does not affect the counter.

## Timing
- Reset (nrst=0, asynchronous, takes effect immediately):
  - pat_r=PATTERN, hist=0, fill=0.
  - y_q=0, match_cnt=0, cnt_sat=0.
  - y=0, because fill=0.
- Release of nrst is synchronous to clk. The first sample can be accepted on the first rising edge after release.
- Latency:
  - y asserts in the same cycle as the final pattern bit (zero latency).
  - y_q and the match_cnt update are visible after the next rising edge.
- The earliest possible match is on the PAT_W-th accepted sample after reset, pat_load, or (with OVERLAP=0) a previous match.
- Reset mid-stream discards all partial history. The match_cnt value is lost.
- With en toggling, only en=1 cycles count toward pattern length. Gaps do not break a match.
- Max match rate:
  - OVERLAP=1: one match per accepted sample, e.g. an all-ones pattern on an all-ones stream.
  - OVERLAP=0: one match per PAT_W accepted samples.

## Test plan
- Default params, en=1, x stream 1,1,0,1,1,0,1 → y=1 on samples 4 and 7 only; y_q=1 one cycle after each; match_cnt=2.
- OVERLAP=0, same stream → y=1 on sample 4 only; match_cnt=1, because samples 5–7 give fill=3 < PAT_W-1+1.
- en gaps: stream 1,1,0,1 with en=0 for 2 cycles between each bit (x randomised during gaps) → single y pulse on the last enabled bit; match_cnt=1.
- pat_load with pat_in=4'b0110 asserted after 1,1,0, together with en=1 and x=1 → y=0 that cycle. Then 0,1,1,0 → y=1 on the 4th bit. The old pattern never matches.
- CNT_W=2, PATTERN=2'b11, PAT_W=2, OVERLAP=1, x=1 for 6 samples → y=1 on samples 2–6. match_cnt goes 1,2,3 then holds at 3; cnt_sat=1 after the third match. cnt_clr in the same cycle as a match → match_cnt=0 and cnt_sat=0.
- Assert nrst low mid-pattern (after 1,1,0), asynchronously between edges → all outputs 0 immediately. After release, 1 alone gives no match and full 1,1,0,1 is required.
